an_sec_locator_seq: RTL and testbench

- Sequential single-error corrector for the 43-bit product (AN) code, A = 17619, carrying a 28-bit payload.
- Accepts a received codeword and computes its remainder mod A bit-serially.
- Searches error locations ±1..±43 by driving an external l-LUT (location -> remainder) and comparing its output against the remainder.
- Emits the corrected codeword with an error location and a status code. Sits directly upstream of the l-LUT and drives its l input.

---
 rtl/an_sec_locator_seq.sv | 172 +++++++++++++++++
 tb/tb_an_sec_locator_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/an_sec_locator_seq.sv
// Bit-serial single-error corrector for an AN code: reduces the received word mod A,
// then walks locations +1,-1,+2,-2,... through an external l-LUT until the remainder matches.
module an_sec_locator_seq #(
    parameter int A    = 17619,
    parameter int CW_W = 43,
    parameter int R_W  = 15,
    parameter int L_W  = 7,
    parameter int NLOC = 43
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CW_W-1:0]         in_cw,
    output logic signed [L_W-1:0]   lut_l,
    input  logic [R_W-1:0]          lut_r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW_W-1:0]         out_cw,
    output logic signed [L_W-1:0]   out_err_loc,
    output logic [1:0]              out_status
);

    localparam int BI_W = $clog2(CW_W);
    localparam int SP_W = $clog2(2 * NLOC);
    localparam int MG_W = SP_W - 1;

    localparam logic [BI_W-1:0] BIT_MSB   = BI_W'(CW_W - 1);
    localparam logic [SP_W-1:0] LAST_STEP = SP_W'(2 * NLOC - 1);
    localparam logic [R_W:0]    A_EXT     = (R_W + 1)'(A);

    localparam logic [1:0] STATUS_OK    = 2'b00;
    localparam logic [1:0] STATUS_FIXED = 2'b01;
    localparam logic [1:0] STATUS_FAIL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        MOD,
        SEARCH,
        DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW_W-1:0]        cw_reg, cw_next;
    logic [R_W-1:0]         rem_reg, rem_next;
    logic [BI_W-1:0]        bit_idx_reg, bit_idx_next;
    logic [SP_W-1:0]        step_reg, step_next;
    logic [CW_W-1:0]        res_cw_reg, res_cw_next;
    logic signed [L_W-1:0]  res_loc_reg, res_loc_next;
    logic [1:0]             res_status_reg, res_status_next;

    // One step of the serial reduction: rem < A guarantees 2*rem+bit < 2A.
    logic [R_W:0]           mod_t;
    logic [R_W-1:0]         rem_step;

    // Location search datapath derived from the step counter.
    logic [MG_W-1:0]        mag;
    logic [L_W-1:0]         loc_mag;
    logic signed [L_W-1:0]  search_loc;
    logic [CW_W-1:0]        pow2;
    logic [CW_W-1:0]        cw_minus;
    logic [CW_W-1:0]        cw_plus;
    logic                   hit;

    assign mod_t    = {rem_reg, cw_reg[bit_idx_reg]};
    assign rem_step = (mod_t >= A_EXT) ? R_W'(mod_t - A_EXT) : R_W'(mod_t);

    assign mag        = step_reg[SP_W-1:1];
    assign loc_mag    = L_W'(mag) + L_W'(1);
    assign search_loc = step_reg[0] ? $signed(L_W'(0) - loc_mag) : $signed(loc_mag);
    assign pow2       = CW_W'(1) << mag;
    assign cw_minus   = cw_reg - pow2;
    assign cw_plus    = cw_reg + pow2;
    assign hit        = (lut_r == rem_reg);

    assign lut_l       = (state_reg == SEARCH) ? search_loc : '0;
    assign in_ready    = (state_reg == IDLE) && rst_n;
    assign out_valid   = (state_reg == DONE);
    assign out_cw      = res_cw_reg;
    assign out_err_loc = res_loc_reg;
    assign out_status  = res_status_reg;

    always_comb begin
        state_next      = state_reg;
        cw_next         = cw_reg;
        rem_next        = rem_reg;
        bit_idx_next    = bit_idx_reg;
        step_next       = step_reg;
        res_cw_next     = res_cw_reg;
        res_loc_next    = res_loc_reg;
        res_status_next = res_status_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    cw_next      = in_cw;
                    rem_next     = '0;
                    bit_idx_next = BIT_MSB;
                    step_next    = '0;
                    state_next   = MOD;
                end
            end

            MOD: begin
                rem_next = rem_step;
                if (bit_idx_reg == '0) begin
                    if (rem_step == '0) begin
                        res_cw_next     = cw_reg;
                        res_loc_next    = '0;
                        res_status_next = STATUS_OK;
                        state_next      = DONE;
                    end else begin
                        step_next  = '0;
                        state_next = SEARCH;
                    end
                end else begin
                    bit_idx_next = bit_idx_reg - BI_W'(1);
                end
            end

            SEARCH: begin
                if (hit) begin
                    // A +k match means the channel added 2^(k-1), so undo it by subtracting.
                    res_cw_next     = step_reg[0] ? cw_plus : cw_minus;
                    res_loc_next    = search_loc;
                    res_status_next = STATUS_FIXED;
                    state_next      = DONE;
                end else if (step_reg == LAST_STEP) begin
                    res_cw_next     = cw_reg;
                    res_loc_next    = '0;
                    res_status_next = STATUS_FAIL;
                    state_next      = DONE;
                end else begin
                    step_next = step_reg + SP_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cw_reg         <= '0;
            rem_reg        <= '0;
            bit_idx_reg    <= '0;
            step_reg       <= '0;
            res_cw_reg     <= '0;
            res_loc_reg    <= '0;
            res_status_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cw_reg         <= cw_next;
            rem_reg        <= rem_next;
            bit_idx_reg    <= bit_idx_next;
            step_reg       <= step_next;
            res_cw_reg     <= res_cw_next;
            res_loc_reg    <= res_loc_next;
            res_status_reg <= res_status_next;
        end
    end

endmodule

// File: tb/tb_an_sec_locator_seq.sv
// Testbench for an_sec_locator_seq: the l-LUT and a mod-A reference model live here,
// directed plan vectors plus randomized codewords are checked for result and latency.
module tb_an_sec_locator_seq;

    localparam int A    = 17619;
    localparam int CW_W = 43;
    localparam int R_W  = 15;
    localparam int L_W  = 7;
    localparam int NLOC = 43;
    localparam int MAX_WAIT = 200;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [CW_W-1:0]        in_cw;
    logic signed [L_W-1:0]  lut_l;
    logic [R_W-1:0]         lut_r;
    logic                   out_valid;
    logic                   out_ready;
    logic [CW_W-1:0]        out_cw;
    logic signed [L_W-1:0]  out_err_loc;
    logic [1:0]             out_status;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_txn  = 0;

    always #5 clk = ~clk;

    an_sec_locator_seq #(
        .A(A), .CW_W(CW_W), .R_W(R_W), .L_W(L_W), .NLOC(NLOC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cw      (in_cw),
        .lut_l      (lut_l),
        .lut_r      (lut_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cw     (out_cw),
        .out_err_loc(out_err_loc),
        .out_status (out_status)
    );

    // l-LUT: the remainder of an error of +/-2^(|l|-1) modulo A.
    function automatic logic [R_W-1:0] lut_fn(input logic signed [L_W-1:0] l);
        int m;
        longint unsigned p;
        if (l == 0) return '0;
        m = (l > 0) ? int'(l) : -int'(l);
        p = (64'd1 << (m - 1)) % longint'(A);
        if (l > 0) return R_W'(p);
        return R_W'((longint'(A) - p) % longint'(A));
    endfunction

    always_comb lut_r = lut_fn(lut_l);

    // Reference: plain arithmetic search over locations in +1,-1,+2,-2,... order.
    task automatic model(input logic [CW_W-1:0] cw,
                         output logic [CW_W-1:0] ecw, output logic signed [L_W-1:0] eloc,
                         output logic [1:0] est, output int elat, output int esteps);
        longint unsigned rem, p, r, mask, v;
        int k;
        mask = (64'd1 << CW_W) - 1;
        v    = 64'(cw);
        rem  = v % longint'(A);
        ecw = cw; eloc = '0; est = 2'b10; elat = 130; esteps = 2 * NLOC;
        if (rem == 0) begin
            est = 2'b00; elat = 44; esteps = 0;
            return;
        end
        for (int i = 0; i < 2 * NLOC; i++) begin
            k = i / 2 + 1;
            p = (64'd1 << (k - 1)) % longint'(A);
            r = (i % 2 == 0) ? p : (longint'(A) - p);
            if (r == rem) begin
                if (i % 2 == 0) begin
                    ecw  = CW_W'((v - (64'd1 << (k - 1))) & mask);
                    eloc = L_W'(k);
                end else begin
                    ecw  = CW_W'((v + (64'd1 << (k - 1))) & mask);
                    eloc = L_W'(-k);
                end
                est = 2'b01; elat = 45 + i; esteps = i + 1;
                return;
            end
        end
    endtask

    // Starts in IDLE, #1 after an edge; returns in the first cycle out_valid is seen.
    task automatic run_txn(input logic [CW_W-1:0] cw, output int lat, output int nz,
                           output logic rdy0, output logic [CW_W-1:0] ocw,
                           output logic signed [L_W-1:0] oloc, output logic [1:0] ost);
        rdy0     = in_ready;
        in_valid = 1'b1;
        in_cw    = cw;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        nz  = 0;
        while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
            if (lut_l !== '0) nz++;
            @(posedge clk); #1;
            lat++;
        end
        ocw  = out_cw;
        oloc = out_err_loc;
        ost  = out_status;
        n_txn++;
        $display("txn %0d cw=%0d lat=%0d out_cw=%0d loc=%0d status=%b lut_steps=%0d",
                 n_txn, cw, lat, ocw, oloc, ost, nz);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_cw = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_cw !== '0) begin n_fail++; $display("FAIL reset_out_cw got=%0d want=0", out_cw); end
        n_cmp++; if (out_err_loc !== '0) begin n_fail++; $display("FAIL reset_err_loc got=%0d want=0", out_err_loc); end
        n_cmp++; if (out_status !== 2'b00) begin n_fail++; $display("FAIL reset_status got=%b want=00", out_status); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        n_cmp++; if (lut_l !== '0) begin n_fail++; $display("FAIL reset_lut_l got=%0d want=0", lut_l); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_plan_vectors();
        logic [CW_W-1:0] cw_tab [5];
        logic [CW_W-1:0] ecw_tab [5];
        int loc_tab [5];
        logic [1:0] st_tab [5];
        int lat_tab [5];
        int lat, nz;
        logic rdy0;
        logic [CW_W-1:0] ocw;
        logic signed [L_W-1:0] oloc;
        logic [1:0] ost;
        cw_tab  = '{43'd88095, 43'd88096, 43'd88091, 43'd4398046599199, 43'd88098};
        ecw_tab = '{43'd88095, 43'd88095, 43'd88095, 43'd88095, 43'd88098};
        loc_tab = '{0, 1, -3, 43, 0};
        st_tab  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
        lat_tab = '{44, 45, 50, 129, 130};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_txn(cw_tab[i], lat, nz, rdy0, ocw, oloc, ost);
            n_cmp++; if (lat !== lat_tab[i]) begin n_fail++; $display("FAIL plan%0d_latency got=%0d want=%0d", i + 1, lat, lat_tab[i]); end
            n_cmp++; if (ocw !== ecw_tab[i]) begin n_fail++; $display("FAIL plan%0d_out_cw got=%0d want=%0d", i + 1, ocw, ecw_tab[i]); end
            n_cmp++; if (oloc !== L_W'(loc_tab[i])) begin n_fail++; $display("FAIL plan%0d_err_loc got=%0d want=%0d", i + 1, oloc, loc_tab[i]); end
            n_cmp++; if (ost !== st_tab[i]) begin n_fail++; $display("FAIL plan%0d_status got=%b want=%b", i + 1, ost, st_tab[i]); end
            n_cmp++; if (nz !== lat_tab[i] - 44) begin n_fail++; $display("FAIL plan%0d_lut_steps got=%0d want=%0d", i + 1, nz, lat_tab[i] - 44); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL plan%0d_valid_fall got=%b want=0", i + 1, out_valid); end
        end
    endtask

    task automatic test_random();
        logic [CW_W-1:0] cw, ecw, ocw;
        logic signed [L_W-1:0] eloc, oloc;
        logic [1:0] est, ost;
        int elat, esteps, lat, nz, kind, j;
        logic rdy0;
        longint unsigned n, base;
        out_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            n    = longint'($urandom) & 64'h0FFF_FFFF;
            base = n * longint'(A);
            kind = int'($urandom_range(0, 3));
            j    = int'($urandom_range(0, CW_W - 1));
            case (kind)
                0: cw = CW_W'(base);
                1: cw = CW_W'(base + (64'd1 << j));
                2: cw = CW_W'(base - (64'd1 << j));
                default: cw = CW_W'({$urandom, $urandom});
            endcase
            model(cw, ecw, eloc, est, elat, esteps);
            run_txn(cw, lat, nz, rdy0, ocw, oloc, ost);
            n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL rand%0d_latency got=%0d want=%0d", t, lat, elat); end
            n_cmp++; if (ocw !== ecw) begin n_fail++; $display("FAIL rand%0d_out_cw got=%0d want=%0d", t, ocw, ecw); end
            n_cmp++; if (oloc !== eloc) begin n_fail++; $display("FAIL rand%0d_err_loc got=%0d want=%0d", t, oloc, eloc); end
            n_cmp++; if (ost !== est) begin n_fail++; $display("FAIL rand%0d_status got=%b want=%b", t, ost, est); end
            n_cmp++; if (nz !== esteps) begin n_fail++; $display("FAIL rand%0d_lut_steps got=%0d want=%0d", t, nz, esteps); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat, nz;
        logic rdy0;
        logic [CW_W-1:0] ocw;
        logic signed [L_W-1:0] oloc;
        logic [1:0] ost;
        out_ready = 1'b0;
        run_txn(43'd88096, lat, nz, rdy0, ocw, oloc, ost);
        n_cmp++; if (ocw !== 43'd88095) begin n_fail++; $display("FAIL bp_out_cw got=%0d want=88095", ocw); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_cw    = CW_W'({$urandom, $urandom});
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_valid got=%b want=1", c, out_valid); end
            n_cmp++; if (out_cw !== 43'd88095) begin n_fail++; $display("FAIL bp%0d_out_cw got=%0d want=88095", c, out_cw); end
            n_cmp++; if (out_err_loc !== L_W'(1)) begin n_fail++; $display("FAIL bp%0d_err_loc got=%0d want=1", c, out_err_loc); end
            n_cmp++; if (out_status !== 2'b01) begin n_fail++; $display("FAIL bp%0d_status got=%b want=01", c, out_status); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready got=%b want=0", c, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic saw_valid;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_cw     = 43'd88091;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
        n_cmp++; if (out_cw !== '0) begin n_fail++; $display("FAIL midrst_out_cw got=%0d want=0", out_cw); end
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        n_cmp++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stray_result got=%b want=0", saw_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [CW_W-1:0] cw, ecw, ocw;
        logic signed [L_W-1:0] eloc, oloc;
        logic [1:0] est, ost;
        int elat, esteps, lat, nz;
        logic rdy0;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cw = CW_W'(64'd88095 * 64'(t + 1) + (64'd1 << (t * 7)));
            model(cw, ecw, eloc, est, elat, esteps);
            run_txn(cw, lat, nz, rdy0, ocw, oloc, ost);
            n_cmp++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_in_ready got=%b want=1", t, rdy0); end
            n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL b2b%0d_latency got=%0d want=%0d", t, lat, elat); end
            n_cmp++; if (ocw !== ecw) begin n_fail++; $display("FAIL b2b%0d_out_cw got=%0d want=%0d", t, ocw, ecw); end
            n_cmp++; if (oloc !== eloc) begin n_fail++; $display("FAIL b2b%0d_err_loc got=%0d want=%0d", t, oloc, eloc); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
